// File: rtl/pong_pkg.sv
// pong_pkg: shared game types and default playfield geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    PLAY  = 1'b1
  } ball_state_t;

  localparam int X_PAD_L    = 30;
  localparam int X_PAD_R    = 979;
  localparam int PAD_HEIGHT = 145;
  localparam int BALL_SIZE  = 15;

endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry shared by the video timing and game-logic blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

endpackage

// File: rtl/ball_engine_if.sv
// ball_engine_if: frame strobe, paddle inputs and ball/score outputs of the ball engine.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
// Modports: master = game/paddle side (drives tick, enable, paddles), slave = ball engine.
interface ball_engine_if #(
  parameter int VEL_MAX = 6
);

  localparam int VEL_W = $clog2(VEL_MAX + 1);

  logic             timing_tick;
  logic             enable;
  logic [9:0]       y_pad_left;
  logic [9:0]       y_pad_right;
  logic [10:0]      x_ball;
  logic [9:0]       y_ball;
  logic [VEL_W-1:0] velocity;
  logic             serving;
  logic             hit;
  logic             miss_left;
  logic             miss_right;

  modport master (
    output timing_tick, enable, y_pad_left, y_pad_right,
    input  x_ball, y_ball, velocity, serving, hit, miss_left, miss_right
  );

  modport slave (
    input  timing_tick, enable, y_pad_left, y_pad_right,
    output x_ball, y_ball, velocity, serving, hit, miss_left, miss_right
  );

endinterface

// File: rtl/ball_speed_ctrl.sv
// ball_speed_ctrl: paddle-hit counter and saturating ball velocity register.
// Latency: velocity updates on the edge that samples the hit/serve_reset strobe.
// Backpressure: none; strobes must already be qualified by the caller.
// Ports: clk, rst (sync, active high), hit (qualified paddle bounce),
//        serve_reset (qualified miss; restores VEL_INIT), velocity (current speed).
module ball_speed_ctrl #(
  parameter int VEL_INIT         = 2,
  parameter int VEL_MAX          = 6,
  parameter int HITS_PER_SPEEDUP = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hit,
  input  logic                             serve_reset,
  output logic [$clog2(VEL_MAX+1)-1:0]     velocity
);

  localparam int VEL_W = $clog2(VEL_MAX + 1);
  localparam int HC_W  = $clog2(HITS_PER_SPEEDUP + 1);

  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [VEL_W-1:0] vel_q, vel_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vel_d  = vel_q;
    if (serve_reset) begin
      hcnt_d = '0;
      vel_d  = VEL_W'(VEL_INIT);
    end else if (hit) begin
      if (hcnt_q == HC_W'(HITS_PER_SPEEDUP - 1)) begin
        hcnt_d = '0;
        if (vel_q < VEL_W'(VEL_MAX)) begin
          vel_d = vel_q + VEL_W'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vel_q  <= VEL_W'(VEL_INIT);
    end else begin
      hcnt_q <= hcnt_d;
      vel_q  <= vel_d;
    end
  end

  assign velocity = vel_q;

endmodule

// File: rtl/ball_engine.sv
// ball_engine: serve/play ball motion with wall and paddle bounces, miss detection, speed-up.
// Latency: one cycle; all outputs update on the edge sampling a qualifying tick.
// Backpressure: none; enable low freezes all state and ignores ticks.
// Ports: clk, rst (sync, active high), bus (ball_engine_if.slave: tick, enable,
//        paddle tops in; ball position, velocity, serving, hit/miss pulses out).
module ball_engine
  import pong_pkg::*;
#(
  parameter int HOR_PIXELS       = vga_pkg::HOR_PIXELS,
  parameter int VER_PIXELS       = vga_pkg::VER_PIXELS,
  parameter int BALL_SIZE        = pong_pkg::BALL_SIZE,
  parameter int X_PAD_L          = pong_pkg::X_PAD_L,
  parameter int X_PAD_R          = pong_pkg::X_PAD_R,
  parameter int PAD_HEIGHT       = pong_pkg::PAD_HEIGHT,
  parameter int WALL_MARGIN      = 5,
  parameter int MISS_MARGIN      = 8,
  parameter int VEL_INIT         = 2,
  parameter int VEL_MAX          = 6,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SERVE_TICKS      = 60
) (
  input  logic          clk,
  input  logic          rst,
  ball_engine_if.slave  bus
);

  localparam int VEL_W = $clog2(VEL_MAX + 1);
  localparam int SC_W  = $clog2(SERVE_TICKS + 1);

  localparam logic [11:0] X_MAX12 = 12'(HOR_PIXELS - BALL_SIZE);
  localparam logic [11:0] Y_MAX12 = 12'(VER_PIXELS - BALL_SIZE);
  localparam logic [10:0] X_CTR   = 11'((HOR_PIXELS - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR   = 10'((VER_PIXELS - BALL_SIZE) / 2);
  localparam logic [11:0] BS12    = 12'(BALL_SIZE);
  localparam logic [11:0] PH12    = 12'(PAD_HEIGHT);

  ball_state_t       state_q, state_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic              right_q, right_d;
  logic              down_q, down_d;
  logic [10:0]       x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              hit_q, hit_d;
  logic              ml_q, ml_d;
  logic              mr_q, mr_d;
  logic [VEL_W-1:0]  vel;

  logic        tick;
  logic [11:0] x12, y12, v12, pl12, pr12;
  logic [11:0] x_sum, y_sum;
  logic [10:0] x_cl;
  logic [9:0]  y_cl;
  logic        hit_r, hit_l, paddle_hit, miss_l, miss_r;

  assign tick = bus.timing_tick & bus.enable;
  assign x12  = 12'(x_q);
  assign y12  = 12'(y_q);
  assign v12  = 12'(vel);
  assign pl12 = 12'(bus.y_pad_left);
  assign pr12 = 12'(bus.y_pad_right);

  // Operands are far below 2048, so a subtraction that goes negative wraps
  // with bit 11 set; that is the clamp-to-zero case.
  assign x_sum = right_q ? (x12 + v12) : (x12 - v12);
  assign y_sum = down_q  ? (y12 + v12) : (y12 - v12);
  assign x_cl  = x_sum[11] ? '0 : ((x_sum > X_MAX12) ? X_MAX12[10:0] : x_sum[10:0]);
  assign y_cl  = y_sum[11] ? '0 : ((y_sum > Y_MAX12) ? Y_MAX12[9:0]  : y_sum[9:0]);

  assign hit_r = right_q && (x12 + BS12 >= 12'(X_PAD_R))
              && (y12 + BS12 >= pr12) && (y12 <= pr12 + PH12);
  assign hit_l = !right_q && (x12 <= 12'(X_PAD_L + BALL_SIZE))
              && (y12 + BS12 >= pl12) && (y12 <= pl12 + PH12);
  assign paddle_hit = hit_r | hit_l;

  // A paddle hit wins over a miss on the same tick.
  assign miss_l = !paddle_hit && !right_q && (x12 <= 12'(MISS_MARGIN));
  assign miss_r = !paddle_hit &&  right_q && (x12 >= X_MAX12 - 12'(MISS_MARGIN));

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    right_d = right_q;
    down_d  = down_q;
    x_d     = x_q;
    y_d     = y_q;
    hit_d   = 1'b0;
    ml_d    = 1'b0;
    mr_d    = 1'b0;
    case (state_q)
      SERVE: begin
        if (tick) begin
          if (scnt_q == SC_W'(SERVE_TICKS - 1)) begin
            scnt_d  = '0;
            state_d = PLAY;
          end else begin
            scnt_d = scnt_q + SC_W'(1);
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (miss_l || miss_r) begin
            state_d = SERVE;
            x_d     = X_CTR;
            y_d     = Y_CTR;
            right_d = miss_r;  // next serve heads toward the player who missed
            ml_d    = miss_l;
            mr_d    = miss_r;
          end else begin
            x_d = x_cl;
            y_d = y_cl;
            if (down_q && (y12 >= Y_MAX12 - 12'(WALL_MARGIN))) begin
              down_d = 1'b0;
            end else if (!down_q && (y12 <= 12'(WALL_MARGIN))) begin
              down_d = 1'b1;
            end
            if (hit_r) right_d = 1'b0;
            if (hit_l) right_d = 1'b1;
            hit_d = paddle_hit;
          end
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE;
      scnt_q  <= '0;
      right_q <= 1'b1;
      down_q  <= 1'b1;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      hit_q   <= 1'b0;
      ml_q    <= 1'b0;
      mr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      right_q <= right_d;
      down_q  <= down_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hit_q   <= hit_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
    end
  end

  ball_speed_ctrl #(
    .VEL_INIT         (VEL_INIT),
    .VEL_MAX          (VEL_MAX),
    .HITS_PER_SPEEDUP (HITS_PER_SPEEDUP)
  ) u_speed (
    .clk         (clk),
    .rst         (rst),
    .hit         (tick && (state_q == PLAY) && paddle_hit),
    .serve_reset (tick && (state_q == PLAY) && (miss_l || miss_r)),
    .velocity    (vel)
  );

  assign bus.x_ball     = x_q;
  assign bus.y_ball     = y_q;
  assign bus.velocity   = vel;
  assign bus.serving    = (state_q == SERVE);
  assign bus.hit        = hit_q;
  assign bus.miss_left  = ml_q;
  assign bus.miss_right = mr_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: scoreboard bench for ball_engine against a behavioural model.
// Latency: expectations are pushed at drive time and popped one edge later.
// Backpressure: n/a.
module tb_ball_engine;

  localparam int BS = 15, XPL = 30, XPR = 979, PH = 145;
  localparam int XMAX = 1009, YMAX = 753, XC = 504, YC = 376;
  localparam int WM = 5, MM = 8, VI = 2, VMAX = 6, HPS = 4, ST = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ball_engine_if #(.VEL_MAX(6)) bus ();

  ball_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [2:0]  v;
    logic        serving;
    logic        hit;
    logic        ml;
    logic        mr;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int mx, my, mv, mscnt, mhcnt;
  bit mserve, mright, mdown, mhit, mml, mmr;

  // observation statistics
  int hits_seen = 0, dbl_hit = 0, max_v = 0, max_y = 0;
  bit prev_hit = 0, seen3 = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int trk(input int y);
    return (y >= 10) ? y - 10 : 0;
  endfunction

  // paddle position that cannot touch a ball at y
  function automatic int away(input int y);
    return (y < 380) ? 600 : 0;
  endfunction

  task automatic model_reset();
    mx = XC; my = YC; mv = VI; mscnt = 0; mhcnt = 0;
    mserve = 1; mright = 1; mdown = 1; mhit = 0; mml = 0; mmr = 0;
  endtask

  task automatic model_tick(input bit tk, input int pl, input int pr);
    bit hr, hl, ph, ml, mr;
    int nx, ny;
    mhit = 0; mml = 0; mmr = 0;
    if (tk) begin
      if (mserve) begin
        if (mscnt == ST - 1) begin
          mscnt = 0;
          mserve = 0;
        end else begin
          mscnt++;
        end
      end else begin
        hr = mright && (mx + BS >= XPR) && (my + BS >= pr) && (my <= pr + PH);
        hl = !mright && (mx <= XPL + BS) && (my + BS >= pl) && (my <= pl + PH);
        ph = hr || hl;
        ml = !ph && !mright && (mx <= MM);
        mr = !ph && mright && (mx >= XMAX - MM);
        if (ml || mr) begin
          mml = ml; mmr = mr;
          mserve = 1; mx = XC; my = YC; mv = VI; mhcnt = 0; mright = mr;
        end else begin
          nx = mright ? mx + mv : mx - mv;
          ny = mdown ? my + mv : my - mv;
          if (nx < 0) nx = 0;
          if (nx > XMAX) nx = XMAX;
          if (ny < 0) ny = 0;
          if (ny > YMAX) ny = YMAX;
          if (mdown && my >= YMAX - WM) mdown = 0;
          else if (!mdown && my <= WM) mdown = 1;
          if (hr) mright = 0;
          if (hl) mright = 1;
          if (ph) begin
            mhit = 1;
            mhcnt++;
            if (mhcnt == HPS) begin
              mhcnt = 0;
              if (mv < VMAX) mv++;
            end
          end
          mx = nx; my = ny;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit tk, input bit en, input int pl, input int pr);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.timing_tick = tk;
    bus.enable = en;
    bus.y_pad_left = 10'(pl);
    bus.y_pad_right = 10'(pr);
    if (r) model_reset();
    else model_tick(tk && en, pl, pr);
    e.x = 11'(mx); e.y = 10'(my); e.v = 3'(mv); e.serving = mserve;
    e.hit = mhit; e.ml = mml; e.mr = mmr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_x", bus.x_ball, e.x);
    check("sb_y", bus.y_ball, e.y);
    check("sb_vel", bus.velocity, e.v);
    check("sb_serving", bus.serving, e.serving);
    check("sb_hit", bus.hit, e.hit);
    check("sb_miss_left", bus.miss_left, e.ml);
    check("sb_miss_right", bus.miss_right, e.mr);
    if (bus.hit === 1'b1 && prev_hit) dbl_hit++;
    prev_hit = (bus.hit === 1'b1);
    if (bus.hit === 1'b1) hits_seen++;
    if (bus.miss_left === 1'b1 || bus.miss_right === 1'b1) hits_seen = 0;
    if (int'(bus.velocity) > max_v) max_v = int'(bus.velocity);
    if (int'(bus.y_ball) > max_y) max_y = int'(bus.y_ball);
    if (!seen3 && bus.velocity == 3'd3) begin
      seen3 = 1;
      check("hits_at_vel3", hits_seen, 4);
    end
  endtask

  initial begin
    int sx, sy;
    bit seen;
    rst = 1'b1;
    bus.timing_tick = 1'b0;
    bus.enable = 1'b1;
    bus.y_pad_left = '0;
    bus.y_pad_right = '0;
    model_reset();

    // reset
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    check("rst_x", bus.x_ball, 504);
    check("rst_y", bus.y_ball, 376);
    check("rst_vel", bus.velocity, 2);
    check("rst_serving", bus.serving, 1);
    check("rst_pulses", {bus.hit, bus.miss_left, bus.miss_right}, 0);

    // serve: held at centre for 59 ticks, leaves SERVE on the 60th
    for (int i = 0; i < 59; i++) drive(0, 1, 1, 0, 0);
    check("serve_hold_serving", bus.serving, 1);
    check("serve_hold_x", bus.x_ball, 504);
    drive(0, 1, 1, 0, 0);
    check("serve_exit_serving", bus.serving, 0);
    check("serve_exit_x", bus.x_ball, 504);
    drive(0, 1, 1, 0, 0);
    check("first_play_x", bus.x_ball, 506);
    check("first_play_y", bus.y_ball, 378);

    // long rally with both paddles tracking: wall bounces, hits, speed-up to saturation
    for (int c = 0; c < 10000; c++) begin
      drive(0, (c % 5) != 4, 1, trk(my), trk(my));
    end
    check("saw_vel3", seen3, 1);
    check("vel_saturated", max_v, 6);
    check("y_in_range", max_y <= YMAX, 1);
    check("hit_one_cycle", dbl_hit, 0);

    // left player misses
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      drive(0, 1, 1, away(my), trk(my));
      if (bus.miss_left === 1'b1) seen = 1;
    end
    check("miss_left_seen", seen, 1);
    check("after_miss_x", bus.x_ball, 504);
    check("after_miss_y", bus.y_ball, 376);
    check("after_miss_vel", bus.velocity, 2);
    check("after_miss_serving", bus.serving, 1);
    for (int i = 0; i < ST; i++) drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, away(my), trk(my));
    check("serve_toward_left_x", bus.x_ball, 502);

    // paddle hit and miss condition on the same tick: only hit fires
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (mx <= MM) begin
        drive(0, 1, 1, trk(my), trk(my));
        check("prio_hit", bus.hit, 1);
        check("prio_no_miss", bus.miss_left, 0);
        seen = 1;
      end else begin
        drive(0, 1, 1, away(my), trk(my));
      end
    end
    check("prio_reached", seen, 1);

    // right player misses
    seen = 0;
    for (int c = 0; c < 1500 && !seen; c++) begin
      drive(0, 1, 1, trk(my), away(my));
      if (bus.miss_right === 1'b1) seen = 1;
    end
    check("miss_right_seen", seen, 1);
    check("miss_right_serving", bus.serving, 1);

    // freeze in PLAY
    for (int i = 0; i < ST + 5; i++) drive(0, 1, 1, trk(my), trk(my));
    sx = mx; sy = my;
    for (int i = 0; i < 100; i++) drive(0, 1, 0, trk(my), trk(my));
    check("freeze_x", bus.x_ball, sx);
    check("freeze_y", bus.y_ball, sy);
    check("freeze_serving", bus.serving, 0);

    // reset during play
    drive(0, 1, 1, trk(my), trk(my));
    drive(1, 1, 1, trk(my), trk(my));
    check("midrst_x", bus.x_ball, 504);
    check("midrst_y", bus.y_ball, 376);
    check("midrst_vel", bus.velocity, 2);
    check("midrst_serving", bus.serving, 1);
    drive(0, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
